digit_emit: RTL and testbench

DIGIT_EMIT -- requirements
Module: digit_emit

---
 rtl/digit_pkg.sv | 15 +
 rtl/lz_count.sv | 22 ++
 rtl/digit_emit.sv | 124 ++++++++++++
 tb/tb_digit_emit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared types and constants for the hex digit emitter and its helpers.
package digit_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int IDX_W      = 3;
    localparam int GAP_W      = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

endpackage

// File: rtl/lz_count.sv
// Counts leading zero hex digits of a word; an all-zero word reports DIGITS-1
// so that exactly one digit (the final 0) is still emitted.
module lz_count
    import digit_pkg::*;
#(
    parameter int DIGITS = MAX_DIGITS
) (
    input  logic [DIGIT_W*DIGITS-1:0] din_i,
    output logic [IDX_W-1:0]          lz_o
);

    always_comb begin
        lz_o = IDX_W'(DIGITS - 1);
        // Scanning upward lets the most significant nonzero digit win.
        for (int i = 0; i < DIGITS; i++) begin
            if (din_i[DIGIT_W*i +: DIGIT_W] != '0) begin
                lz_o = IDX_W'(DIGITS - 1 - i);
            end
        end
    end

endmodule

// File: rtl/digit_emit.sv
// Serialises a captured word into hex digits over a valid/ready handshake,
// most significant first. Define DIGIT_EMIT_LZS_EN to skip leading zero digits.
module digit_emit
    import digit_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int GAP    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIGIT_W*DIGITS-1:0] din,
    input  logic                      load,
    output logic                      busy,
    output logic [DIGIT_W-1:0]        hex_out,
    output logic                      hex_valid,
    input  logic                      hex_ready,
    output logic [IDX_W-1:0]          idx,
    output logic                      last,
    output logic                      done
);

    localparam int WORD_W = DIGIT_W * DIGITS;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               done_q, done_d;

    logic [IDX_W-1:0]   first_idx;
    logic [WORD_W-1:0]  load_word;
    logic               handshake;

`ifdef DIGIT_EMIT_LZS_EN
    logic [IDX_W-1:0]   lz;

    lz_count #(
        .DIGITS (DIGITS)
    ) u_lz_count (
        .din_i (din),
        .lz_o  (lz)
    );

    // Left-justify so the first emitted digit always sits in the top nibble.
    assign first_idx = IDX_W'(DIGITS - 1) - lz;
    assign load_word = din << (DIGIT_W * int'(lz));
`else
    assign first_idx = IDX_W'(DIGITS - 1);
    assign load_word = din;
`endif

    assign handshake = (state_q == S_SEND) && hex_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    word_d  = load_word;
                    idx_d   = first_idx;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (handshake) begin
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        word_d = word_q << DIGIT_W;
                        idx_d  = idx_q - IDX_W'(1);
                        if (GAP == 0) begin
                            state_d = S_SEND;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = GAP_W'(GAP - 1);
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values; reset is synchronous and wins over load.
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign hex_valid = (state_q == S_SEND);
    assign hex_out   = word_q[WORD_W-1 -: DIGIT_W];
    assign idx       = idx_q;
    assign last      = hex_valid && (idx_q == '0);
    assign done      = done_q;

endmodule

// File: tb/tb_digit_emit.sv
// Bench for digit_emit: two instances (GAP=0 and GAP=3) share stimulus and are
// compared every cycle against a digit-list reference model.
module tb_digit_emit;

    localparam int DIGITS = 8;
    localparam int GAP_A  = 0;
    localparam int GAP_B  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        hex_ready;
    logic [31:0] din;

    logic        busy      [2];
    logic        hex_valid [2];
    logic        last      [2];
    logic        done      [2];
    logic [3:0]  hex_out   [2];
    logic [2:0]  idx       [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digit_emit #(.DIGITS(DIGITS), .GAP(GAP_A)) u_gap0 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .load      (load),
        .busy      (busy[0]),
        .hex_out   (hex_out[0]),
        .hex_valid (hex_valid[0]),
        .hex_ready (hex_ready),
        .idx       (idx[0]),
        .last      (last[0]),
        .done      (done[0])
    );

    digit_emit #(.DIGITS(DIGITS), .GAP(GAP_B)) u_gap3 (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .load      (load),
        .busy      (busy[1]),
        .hex_out   (hex_out[1]),
        .hex_valid (hex_valid[1]),
        .hex_ready (hex_ready),
        .idx       (idx[1]),
        .last      (last[1]),
        .done      (done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: the list of digits a word should produce, plus how many
    // idle cycles remain before the next digit is due.
    int m_gap   [2] = '{GAP_A, GAP_B};
    bit m_busy  [2] = '{1'b0, 1'b0};
    bit m_done  [2] = '{1'b0, 1'b0};
    bit m_reset [2] = '{1'b1, 1'b1};
    int m_left  [2] = '{0, 0};
    int m_n     [2] = '{0, 0};
    int m_ptr   [2] = '{0, 0};
    int m_dig   [2][8];
    int m_pos   [2][8];

    function automatic void plan(input int k, input logic [31:0] w);
        int top;
        top = DIGITS - 1;
`ifdef DIGIT_EMIT_LZS_EN
        top = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (((w >> (4 * i)) & 32'hF) != 0) top = i;
        end
`endif
        m_n[k] = 0;
        for (int i = top; i >= 0; i--) begin
            m_dig[k][m_n[k]] = int'((w >> (4 * i)) & 32'hF);
            m_pos[k][m_n[k]] = i;
            m_n[k]++;
        end
        m_ptr[k] = 0;
    endfunction

    function automatic bit cur_valid(input int k);
        return m_busy[k] && (m_left[k] == 0);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ev;
            ev = cur_valid(k);
            check($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
            check($sformatf("hex_valid%0d", k), 32'(hex_valid[k]), 32'(ev));
            check($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
            if (ev) begin
                check($sformatf("hex_out%0d", k), 32'(hex_out[k]), 32'(m_dig[k][m_ptr[k]]));
                check($sformatf("idx%0d", k), 32'(idx[k]), 32'(m_pos[k][m_ptr[k]]));
                check($sformatf("last%0d", k), 32'(last[k]), 32'(m_pos[k][m_ptr[k]] == 0));
            end
            if (m_reset[k]) begin
                check($sformatf("rst_hex_out%0d", k), 32'(hex_out[k]), 32'd0);
                check($sformatf("rst_idx%0d", k), 32'(idx[k]), 32'd0);
                check($sformatf("rst_last%0d", k), 32'(last[k]), 32'd0);
            end

            // Advance the model with the inputs the coming edge will see.
            if (rst) begin
                m_busy[k]  = 1'b0;
                m_done[k]  = 1'b0;
                m_left[k]  = 0;
                m_reset[k] = 1'b1;
            end else begin
                m_reset[k] = 1'b0;
                m_done[k]  = 1'b0;
                if (m_busy[k]) begin
                    if (m_left[k] > 0) begin
                        m_left[k]--;
                    end else if (hex_ready) begin
                        m_ptr[k]++;
                        if (m_ptr[k] == m_n[k]) begin
                            m_busy[k] = 1'b0;
                            m_done[k] = 1'b1;
                        end else begin
                            m_left[k] = m_gap[k];
                        end
                    end
                end else if (load) begin
                    plan(k, din);
                    m_busy[k] = 1'b1;
                    m_left[k] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        din  = w;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300 && (m_busy[0] || m_busy[1]); t++) tick();
        check("idle_timeout", 32'(m_busy[0] || m_busy[1]), 32'd0);
        tick();
    endtask

    // Advance until instance 0 presents the digit at position p.
    task automatic wait_pos0(input int p, output bit reached);
        reached = 1'b0;
        for (int t = 0; t < 100 && !reached; t++) begin
            if (cur_valid(0) && m_pos[0][m_ptr[0]] == p) reached = 1'b1;
            else tick();
        end
    endtask

    initial begin
        bit reached;
        rst       = 1'b1;
        load      = 1'b0;
        hex_ready = 1'b1;
        din       = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Back-to-back digits on GAP=0, gapped digits on GAP=3.
        load_word(32'h1234ABCD);
        wait_idle();

        // Five-cycle stall on position 5.
        load_word(32'h1234ABCD);
        wait_pos0(5, reached);
        check("stall_reach", 32'(reached), 32'd1);
        hex_ready = 1'b0;
        repeat (5) tick();
        hex_ready = 1'b1;
        wait_idle();

        // A second load while busy must be ignored.
        load_word(32'h1234ABCD);
        repeat (2) tick();
        load_word(32'hFFFFFFFF);
        wait_idle();

        // Reset coincident with the position-3 handshake, then a clean restart.
        load_word(32'h1234ABCD);
        wait_pos0(3, reached);
        check("rst_reach", 32'(reached), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        load_word(32'h0000_0007);
        wait_idle();

        // Load in the same cycle as done, and leading-zero words.
        load_word(32'h0000_00A5);
        reached = 1'b0;
        for (int t = 0; t < 100 && !reached; t++) begin
            if (m_done[0]) reached = 1'b1;
            else tick();
        end
        check("done_reach", 32'(reached), 32'd1);
        load_word(32'h0000_0000);
        wait_idle();
        load_word(32'h0000_0000);
        wait_idle();

        // Random traffic: random ready, loads at any time, short words.
        for (int c = 0; c < 600; c++) begin
            hex_ready = ($urandom_range(0, 3) != 0);
            din       = $urandom >> (4 * $urandom_range(0, 8));
            load      = ($urandom_range(0, 5) == 0);
            tick();
        end
        load      = 1'b0;
        hex_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
